stage0: RTL and testbench

Fetch stage of the bpfcpu pipeline, directly upstream of the decode stage. It owns the program counter and issues reads to the instruction memory, which has a 1-cycle read latency. It buffers the returned 64-bit instructions with their cycle-age counts and presents them to decode over a valid/ready handshake. On a branch mispredict it flushes everything it holds and redirects fetch to the corrected PC.

---
 rtl/bpf_defs_pkg.sv | 16 +
 rtl/stage0_fetch_buf.sv | 113 +++++++++++
 rtl/stage0.sv | 128 ++++++++++++
 tb/tb_stage0.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_defs_pkg.sv
// -----------------------------------------------------------------------------
// bpf_defs
//   Constants shared across the bpfcpu pipeline stages.
//   CODE_ADDR_WIDTH : instruction memory address width (PC width)
//   INSTR_WIDTH     : width of one instruction word
//   COUNT_WIDTH     : width of the per-instruction age count
//   FETCH_DEPTH     : number of fetched instructions the fetch stage can hold
// -----------------------------------------------------------------------------
package bpf_defs;

   localparam int CODE_ADDR_WIDTH = 10;
   localparam int INSTR_WIDTH     = 64;
   localparam int COUNT_WIDTH     = 6;
   localparam int FETCH_DEPTH     = 2;

endpackage

// File: rtl/stage0_fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
//   Generic 2-deep FIFO whose entries carry a payload plus a saturating age
//   counter. Every held entry ages on cycles i_cnt_en is high. A pop and a push
//   in the same cycle are both honoured. i_flush empties the FIFO and wins over
//   a simultaneous push.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   i_flush      in   discard all held entries
//   i_push       in   write i_push_data/i_push_cnt at the tail
//   i_push_data  in   payload to store
//   i_push_cnt   in   age count to store with the payload
//   i_pop        in   remove the head entry (ignored when empty)
//   i_cnt_en     in   age every held entry by one this cycle
//   o_head_data  out  head payload (zero when empty)
//   o_head_cnt   out  head age count (zero when empty)
//   o_vld        out  FIFO holds at least one entry
//   o_occupancy  out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module fetch_buf
   import bpf_defs::*;
#(
   parameter int DATA_WIDTH  = bpf_defs::CODE_ADDR_WIDTH + bpf_defs::INSTR_WIDTH,
   parameter int COUNT_WIDTH = bpf_defs::COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [DATA_WIDTH-1:0]  i_push_data,
   input  logic [COUNT_WIDTH-1:0] i_push_cnt,
   input  logic                   i_pop,
   input  logic                   i_cnt_en,
   output logic [DATA_WIDTH-1:0]  o_head_data,
   output logic [COUNT_WIDTH-1:0] o_head_cnt,
   output logic                   o_vld,
   output logic [1:0]             o_occupancy
);

   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   // Slot 0 is always the head; a pop shifts slot 1 down.
   logic [DATA_WIDTH-1:0]  r_data     [FETCH_DEPTH];
   logic [COUNT_WIDTH-1:0] r_cnt      [FETCH_DEPTH];
   logic [1:0]             r_occ;

   logic [DATA_WIDTH-1:0]  w_data_nxt [FETCH_DEPTH];
   logic [COUNT_WIDTH-1:0] w_cnt_nxt  [FETCH_DEPTH];
   logic [COUNT_WIDTH-1:0] w_cnt_aged [FETCH_DEPTH];
   logic [1:0]             w_occ_nxt;
   logic                   w_pop;

   always_comb begin
      // NOTE: combinational logic uses blocking assignments, and every signal
      // gets its default value first so no path through the block leaves it
      // unassigned (which would infer a latch).
      w_pop = i_pop && (r_occ != 2'd0);
      for (int i = 0; i < FETCH_DEPTH; i++) begin
         w_cnt_aged[i] = (i_cnt_en && (r_cnt[i] != CNT_MAX)) ?
                         r_cnt[i] + COUNT_WIDTH'(1) : r_cnt[i];
      end
      w_data_nxt = r_data;
      w_cnt_nxt  = w_cnt_aged;
      w_occ_nxt  = r_occ;

      if (w_pop) begin
         w_data_nxt[0] = r_data[1];
         w_cnt_nxt[0]  = w_cnt_aged[1];
         w_occ_nxt     = r_occ - 2'd1;
      end

      // The push lands behind whatever survives the pop.
      if (i_push && (w_occ_nxt != 2'd2)) begin
         if (w_occ_nxt == 2'd0) begin
            w_data_nxt[0] = i_push_data;
            w_cnt_nxt[0]  = i_push_cnt;
         end else begin
            w_data_nxt[1] = i_push_data;
            w_cnt_nxt[1]  = i_push_cnt;
         end
         w_occ_nxt = w_occ_nxt + 2'd1;
      end

      if (i_flush) begin
         w_occ_nxt = 2'd0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ <= 2'd0;
      end else begin
         r_occ <= w_occ_nxt;
      end
   end

   // NOTE: the slot storage is deliberately not reset; r_occ alone decides
   // which slots are meaningful, and empty slots are masked at the outputs.
   always_ff @(posedge clk) begin
      r_data <= w_data_nxt;
      r_cnt  <= w_cnt_nxt;
   end

   assign o_vld       = (r_occ != 2'd0);
   assign o_head_data = o_vld ? r_data[0] : '0;
   assign o_head_cnt  = o_vld ? r_cnt[0]  : '0;
   assign o_occupancy = r_occ;

endmodule

// File: rtl/stage0.sv
// -----------------------------------------------------------------------------
// stage0
//   Fetch stage of the bpfcpu pipeline. Owns the PC, issues reads to a
//   1-cycle-latency instruction memory, buffers up to two returned
//   instructions with their age counts and hands them to decode over a
//   valid/ready handshake. A branch mispredict flushes everything held or in
//   flight and redirects the PC.
//
// Ports
//   clk                in   clock
//   rst                in   synchronous, active-high reset
//   cpu_en             in   fetch permitted; low freezes PC, no new reads
//   inst_rd_addr       out  instruction memory read address (= PC)
//   inst_rd_en         out  instruction memory read strobe
//   instr_in           in   read data, valid the cycle after inst_rd_en
//   branch_mispredict  in   flush and redirect
//   branch_target      in   corrected PC, used when branch_mispredict is high
//   cnt_en             in   age counters advance on cycles this is high
//   instr_out          out  instruction to decode
//   PC_out             out  address instr_out was fetched from
//   ocount             out  age of instr_out
//   vld                out  instr_out valid
//   next_rdy           in   decode ready
// -----------------------------------------------------------------------------
module stage0
   import bpf_defs::*;
#(
   parameter int CODE_ADDR_WIDTH = bpf_defs::CODE_ADDR_WIDTH,
   parameter int COUNT_WIDTH     = bpf_defs::COUNT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_en,
   output logic [CODE_ADDR_WIDTH-1:0] inst_rd_addr,
   output logic                       inst_rd_en,
   input  logic [INSTR_WIDTH-1:0]     instr_in,
   input  logic                       branch_mispredict,
   input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
   input  logic                       cnt_en,
   output logic [INSTR_WIDTH-1:0]     instr_out,
   output logic [CODE_ADDR_WIDTH-1:0] PC_out,
   output logic [COUNT_WIDTH-1:0]     ocount,
   output logic                       vld,
   input  logic                       next_rdy
);

   localparam int                     DATA_WIDTH = CODE_ADDR_WIDTH + INSTR_WIDTH;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

   logic [CODE_ADDR_WIDTH-1:0] r_pc;
   logic                       r_inflight;
   logic [CODE_ADDR_WIDTH-1:0] r_if_pc;
   logic [COUNT_WIDTH-1:0]     r_if_cnt;

   logic                       w_pop;
   logic                       w_push;
   logic                       w_rd_en;
   logic [1:0]                 w_occ;
   logic [2:0]                 w_committed;
   logic [COUNT_WIDTH-1:0]     w_if_cnt_aged;
   logic [DATA_WIDTH-1:0]      w_head_data;
   logic [COUNT_WIDTH-1:0]     w_head_cnt;
   logic                       w_vld;

   assign w_pop = w_vld && next_rdy;

   // Memory latency is exactly one cycle, so an in-flight read is always the
   // one whose data arrives this cycle. Suppressing its capture on a
   // mispredict is therefore all the discard marking that is needed.
   assign w_push = r_inflight && !branch_mispredict;

   // The in-flight read ages during its one cycle in flight, so it is stored
   // with that cycle's increment already applied.
   assign w_if_cnt_aged = (cnt_en && (r_if_cnt != CNT_MAX)) ?
                          r_if_cnt + COUNT_WIDTH'(1) : r_if_cnt;

   // Credit: slots still spoken for after this cycle's pop, counting the read
   // whose data lands now. A new read needs one free slot on top of those.
   always_comb begin
      w_committed = {1'b0, w_occ} - {2'b00, w_pop} + {2'b00, r_inflight};
      w_rd_en     = cpu_en && !rst && !branch_mispredict && (w_committed <= 3'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= '0;
         r_inflight <= 1'b0;
         r_if_pc    <= '0;
         r_if_cnt   <= '0;
      end else if (branch_mispredict) begin
         r_pc       <= branch_target;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_rd_en) begin
            r_pc     <= r_pc + CODE_ADDR_WIDTH'(1);
            r_if_pc  <= r_pc;
            r_if_cnt <= '0;
         end
      end
   end

   fetch_buf #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_fetch_buf (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (branch_mispredict),
      .i_push      (w_push),
      .i_push_data ({r_if_pc, instr_in}),
      .i_push_cnt  (w_if_cnt_aged),
      .i_pop       (w_pop),
      .i_cnt_en    (cnt_en),
      .o_head_data (w_head_data),
      .o_head_cnt  (w_head_cnt),
      .o_vld       (w_vld),
      .o_occupancy (w_occ)
   );

   assign inst_rd_addr = r_pc;
   assign inst_rd_en   = w_rd_en;
   assign vld          = w_vld;
   assign instr_out    = w_head_data[INSTR_WIDTH-1:0];
   assign PC_out       = w_head_data[DATA_WIDTH-1 -: CODE_ADDR_WIDTH];
   assign ocount       = w_head_cnt;

endmodule

// File: tb/tb_stage0.sv
// -----------------------------------------------------------------------------
// tb_stage0
//   Self-checking bench for stage0. A transaction-level reference model keeps
//   the fetch stage's contents as a queue of {pc, age} plus one in-flight
//   slot, decides from the credit rule whether a read is due, and pushes the
//   expected {instr, pc, age} of every handshake into a scoreboard queue. A
//   separate monitor pops that queue whenever the DUT completes a handshake.
// -----------------------------------------------------------------------------
module tb_stage0;
   import bpf_defs::*;

   localparam int             AW   = 10;
   localparam int             CW   = 6;
   localparam logic [CW-1:0]  CMAX = 6'd63;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   cpu_en;
   logic [AW-1:0]          inst_rd_addr;
   logic                   inst_rd_en;
   logic [INSTR_WIDTH-1:0] instr_in;
   logic                   branch_mispredict;
   logic [AW-1:0]          branch_target;
   logic                   cnt_en;
   logic [INSTR_WIDTH-1:0] instr_out;
   logic [AW-1:0]          PC_out;
   logic [CW-1:0]          ocount;
   logic                   vld;
   logic                   next_rdy;

   always #5 clk = ~clk;

   stage0 #(
      .CODE_ADDR_WIDTH (AW),
      .COUNT_WIDTH     (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cpu_en            (cpu_en),
      .inst_rd_addr      (inst_rd_addr),
      .inst_rd_en        (inst_rd_en),
      .instr_in          (instr_in),
      .branch_mispredict (branch_mispredict),
      .branch_target     (branch_target),
      .cnt_en            (cnt_en),
      .instr_out         (instr_out),
      .PC_out            (PC_out),
      .ocount            (ocount),
      .vld               (vld),
      .next_rdy          (next_rdy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction memory contents: address-tagged words so any mix-up of
   // address, order or staleness shows in both halves of the word.
   function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
      return {16'hC0DE, 6'h00, a, 22'h000000, a};
   endfunction

   // 1-cycle-latency instruction memory.
   logic [63:0] r_mem_q = '0;
   always @(posedge clk) begin
      if (inst_rd_en) r_mem_q <= mem_word(inst_rd_addr);
   end
   assign instr_in = r_mem_q;

   // ---------------- reference model + scoreboard producer ----------------
   typedef struct packed {
      logic [AW-1:0] pc;
      logic [CW-1:0] cnt;
   } ent_t;

   typedef struct packed {
      logic [63:0]   instr;
      logic [AW-1:0] pc;
      logic [CW-1:0] cnt;
   } resp_t;

   ent_t          m_buf[$];
   ent_t          m_if;
   bit            m_if_v   = 1'b0;
   logic [AW-1:0] m_pc     = '0;
   resp_t         sb_q[$];
   bit            model_on = 1'b0;
   bit            m_exp_vld;
   bit            m_pop;
   bit            m_exp_rd;
   int            m_occ_after;
   resp_t         mon_e;

   function automatic logic [CW-1:0] age(input logic [CW-1:0] c, input logic en);
      return (en && (c != CMAX)) ? CW'(c + 1) : c;
   endfunction

   always @(negedge clk) begin
      if (model_on) begin
         m_exp_vld   = (m_buf.size() != 0);
         m_pop       = m_exp_vld && next_rdy;
         m_occ_after = m_buf.size() - (m_pop ? 1 : 0);
         m_exp_rd    = cpu_en && !rst && !branch_mispredict &&
                       ((m_occ_after + (m_if_v ? 1 : 0) + 1) <= 2);

         check("vld", vld, m_exp_vld);
         check("inst_rd_en", inst_rd_en, m_exp_rd);
         check("inst_rd_addr", inst_rd_addr, m_pc);

         if (m_pop) begin
            sb_q.push_back('{mem_word(m_buf[0].pc), m_buf[0].pc, m_buf[0].cnt});
            void'(m_buf.pop_front());
         end

         if (rst) begin
            m_buf.delete();
            m_if_v = 1'b0;
            m_pc   = '0;
         end else if (branch_mispredict) begin
            m_buf.delete();
            m_if_v = 1'b0;
            m_pc   = branch_target;
         end else begin
            foreach (m_buf[i]) m_buf[i].cnt = age(m_buf[i].cnt, cnt_en);
            if (m_if_v) begin
               m_if.cnt = age(m_if.cnt, cnt_en);
               m_buf.push_back(m_if);
               m_if_v = 1'b0;
            end
            if (m_exp_rd) begin
               m_if_v = 1'b1;
               m_if   = '{pc: m_pc, cnt: '0};
               m_pc   = AW'((int'(m_pc) + 1) % (1 << AW));
            end
         end
      end
   end

   // ---------------- scoreboard consumer (monitor) ----------------
   always @(negedge clk) begin
      #1;
      if (model_on && (vld === 1'b1) && (next_rdy === 1'b1)) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake: got PC_out 0x%0h, expected no delivery (t=%0t)", PC_out, $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("instr_out", instr_out, mon_e.instr);
            check("PC_out", PC_out, mon_e.pc);
            check("ocount", ocount, mon_e.cnt);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_vld"}, vld, 1'b0);
      check({tag, "_ocount"}, ocount, '0);
      check({tag, "_PC_out"}, PC_out, '0);
      check({tag, "_instr_out"}, instr_out, '0);
      check({tag, "_rd_addr"}, inst_rd_addr, '0);
   endtask

   initial begin
      rst               = 1'b1;
      cpu_en            = 1'b0;
      branch_mispredict = 1'b0;
      branch_target     = '0;
      cnt_en            = 1'b1;
      next_rdy          = 1'b1;

      // Reset then run: rst high across two edges.
      @(posedge clk);
      #1;
      model_on = 1'b1;
      cpu_en   = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);                       // cycle 0
      check_reset_outputs("reset");
      @(negedge clk);                       // cycle 1
      check("cycle1_vld", vld, 1'b0);
      @(negedge clk);                       // cycle 2: first delivery
      check("first_vld", vld, 1'b1);
      check("first_PC_out", PC_out, '0);
      check("first_instr", instr_out, mem_word('0));
      check("first_ocount", ocount, 6'd1);

      // Backpressure from cycle 3.
      cyc(1);
      next_rdy = 1'b0;
      cyc(8);
      next_rdy = 1'b1;
      cyc(6);

      // Mispredict with a read in flight.
      branch_mispredict = 1'b1;
      branch_target     = 10'h3F0;
      cyc(1);
      branch_mispredict = 1'b0;
      @(negedge clk);
      check("mp_vld_next", vld, 1'b0);
      check("mp_rd_en", inst_rd_en, 1'b1);
      check("mp_rd_addr", inst_rd_addr, 10'h3F0);
      cyc(8);

      // Age saturation, then hold with cnt_en low.
      next_rdy = 1'b0;
      cyc(100);
      @(negedge clk);
      check("sat_ocount", ocount, CMAX);
      cnt_en = 1'b0;
      cyc(5);
      @(negedge clk);
      check("sat_hold", ocount, CMAX);
      next_rdy = 1'b1;
      cyc(4);
      next_rdy = 1'b0;
      cyc(10);
      cnt_en = 1'b1;
      cyc(3);
      next_rdy = 1'b1;
      cyc(4);

      // PC wrap.
      branch_mispredict = 1'b1;
      branch_target     = 10'h3FF;
      cyc(1);
      branch_mispredict = 1'b0;
      cyc(8);

      // rst and branch_mispredict together: rst wins.
      rst               = 1'b1;
      branch_mispredict = 1'b1;
      branch_target     = 10'h155;
      cyc(1);
      rst               = 1'b0;
      branch_mispredict = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_mp");
      cyc(5);

      // rst during full-buffer backpressure.
      next_rdy = 1'b0;
      cyc(6);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_full");
      next_rdy = 1'b1;
      cyc(6);

      // Randomized traffic.
      repeat (800) begin
         cpu_en            = ($urandom % 8) != 0;
         next_rdy          = ($urandom % 3) != 0;
         cnt_en            = ($urandom % 4) != 0;
         branch_mispredict = ($urandom % 25) == 0;
         branch_target     = AW'($urandom);
         rst               = ($urandom % 200) == 0;
         cyc(1);
      end

      // Drain.
      rst               = 1'b0;
      branch_mispredict = 1'b0;
      cpu_en            = 1'b0;
      next_rdy          = 1'b1;
      cyc(6);
      @(negedge clk);
      #2;
      check("scoreboard_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
